// File: rtl/csi_rx_link_ctrl_if.sv
// Control/status bundle between the CSI_RX link supervisor and its surroundings.
// The supervisor connects through the slave modport; the controller side uses master.
interface csi_rx_link_ctrl_if;
  logic        start;
  logic        in_frame;
  logic        in_line;
  logic        cam_en;
  logic        link_reset;
  logic        link_up;
  logic        fail;
  logic [2:0]  state;
  logic [3:0]  retry_cnt;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [11:0] lines_last;

  modport master (
    output start, in_frame, in_line,
    input  cam_en, link_reset, link_up, fail, state, retry_cnt,
           frame_err, frame_cnt, lines_last
  );

  modport slave (
    input  start, in_frame, in_line,
    output cam_en, link_reset, link_up, fail, state, retry_cnt,
           frame_err, frame_cnt, lines_last
  );
endinterface

// File: rtl/csi_rx_link_ctrl.sv
// CSI_RX link supervisor: power-up/reset sequencing, frame watchdog with bounded retry.
// Define CSI_LINK_STATS_EN to build the frame_cnt / lines_last statistics counters.
module csi_rx_link_ctrl #(
  parameter int PWRUP_CYC = 1000,
  parameter int RST_CYC   = 16,
  parameter int WDOG_CYC  = 2000000,
  parameter int MAX_RETRY = 3,
  parameter int EXP_LINES = 0
) (
  input  logic               clock,
  input  logic               reset,
  csi_rx_link_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWRUP    = 3'd1,
    LINK_RST = 3'd2,
    WAIT_SOF = 3'd3,
    STREAM   = 3'd4,
    FAIL     = 3'd5
  } state_e;

  // One shared cycle counter times power-up, link reset and the watchdog.
  localparam int CNT_MAX2 = (PWRUP_CYC > RST_CYC) ? PWRUP_CYC : RST_CYC;
  localparam int CNT_MAX  = (CNT_MAX2 > WDOG_CYC) ? CNT_MAX2 : WDOG_CYC;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] WDOG_LAST  = CW'(WDOG_CYC - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);
  localparam logic [11:0]   EXP_L      = 12'(EXP_LINES);

`ifdef CSI_LINK_STATS_EN
  localparam bit LINE_CNT_EN = 1'b1;
`else
  localparam bit LINE_CNT_EN = (EXP_LINES != 0);
`endif

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detectors for the byte-clock status inputs
  // ---------------------------------------------------------------------------
  logic [1:0] frame_sync_q, line_sync_q;
  logic       frame_prev_q, line_prev_q;
  logic       sof_q, eof_q, sol_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, which the shift chain relies on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_sync_q <= '0;
      line_sync_q  <= '0;
      frame_prev_q <= 1'b0;
      line_prev_q  <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      sol_q        <= 1'b0;
    end else begin
      frame_sync_q <= {frame_sync_q[0], bus.in_frame};
      line_sync_q  <= {line_sync_q[0], bus.in_line};
      frame_prev_q <= frame_sync_q[1];
      line_prev_q  <= line_sync_q[1];
      sof_q        <= frame_sync_q[1] & ~frame_prev_q;
      eof_q        <= ~frame_sync_q[1] & frame_prev_q;
      sol_q        <= line_sync_q[1] & ~line_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic            retry;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    retry   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PWRUP;
          retry_d = '0;
        end
      end
      PWRUP:    if (cnt_q == PWRUP_LAST) state_d = LINK_RST;
      LINK_RST: if (cnt_q == RST_LAST)   state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (sof_q)                   state_d = STREAM;
        else if (cnt_q == WDOG_LAST) retry   = 1'b1;
      end
      STREAM:   if (!sof_q && cnt_q == WDOG_LAST) retry = 1'b1;
      FAIL:     state_d = FAIL;
      default:  state_d = IDLE;
    endcase

    if (retry) begin
      if (MAX_RETRY != 0 && retry_q == RETRY_MAX) begin
        state_d = FAIL;
      end else begin
        state_d = LINK_RST;
        if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
      end
    end

    // Shutdown overrides every other transition, including sof and expiry.
    if (!bus.start) state_d = IDLE;

    cnt_d = cnt_q;
    if (state_d != state_q || (state_q == STREAM && sof_q))
      cnt_d = '0;
    else if (state_q inside {PWRUP, LINK_RST, WAIT_SOF, STREAM})
      cnt_d = cnt_q + CW'(1);
  end

  // ---------------------------------------------------------------------------
  // Line counting and frame-end checks
  // ---------------------------------------------------------------------------
  logic [11:0] line_cnt_q, line_cnt_d, lines_now;
  logic        seen_sof_q, seen_sof_d;
  logic        frame_end;
  logic        frame_err_d;

  always_comb begin
    lines_now   = (sol_q && line_cnt_q != 12'hFFF) ? line_cnt_q + 12'd1 : line_cnt_q;
    line_cnt_d  = sof_q ? {11'd0, sol_q} : lines_now;
    seen_sof_d  = (state_d == STREAM) && (seen_sof_q || sof_q);
    frame_end   = eof_q && (state_q == STREAM) && seen_sof_q;
    frame_err_d = frame_end && (EXP_LINES != 0) && (lines_now != EXP_L);
  end

  if (LINE_CNT_EN) begin : g_line_cnt
    always_ff @(posedge clock or posedge reset) begin
      if (reset) line_cnt_q <= '0;
      else       line_cnt_q <= line_cnt_d;
    end
  end else begin : g_no_line_cnt
    assign line_cnt_q = '0;
  end

  // Outputs are decoded from the next state and registered alongside it.
  logic cam_en_q, link_reset_q, link_up_q, fail_q, frame_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      seen_sof_q   <= 1'b0;
      cam_en_q     <= 1'b0;
      link_reset_q <= 1'b1;
      link_up_q    <= 1'b0;
      fail_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      seen_sof_q   <= seen_sof_d;
      cam_en_q     <= state_d inside {PWRUP, LINK_RST, WAIT_SOF, STREAM};
      link_reset_q <= !(state_d inside {WAIT_SOF, STREAM});
      link_up_q    <= (state_d == STREAM);
      fail_q       <= (state_d == FAIL);
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef CSI_LINK_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [11:0] lines_last_q, lines_last_d;

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    lines_last_d = lines_last_q;
    if (frame_end) begin
      frame_cnt_d  = frame_cnt_q + 16'd1;
      lines_last_d = lines_now;
    end
    if (state_d != STREAM) frame_cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      lines_last_q <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      lines_last_q <= lines_last_d;
    end
  end

  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.lines_last = lines_last_q;
`else
  assign bus.frame_cnt  = '0;
  assign bus.lines_last = '0;
`endif

  assign bus.cam_en     = cam_en_q;
  assign bus.link_reset = link_reset_q;
  assign bus.link_up    = link_up_q;
  assign bus.fail       = fail_q;
  assign bus.state      = state_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_csi_rx_link_ctrl.sv
// Directed bench for csi_rx_link_ctrl: table-driven bring-up plus hand sequences
// for line checking, watchdog retry/FAIL, start-drop priority and async reset.
module tb_csi_rx_link_ctrl;

  localparam int PWRUP_CYC = 20;
  localparam int RST_CYC   = 16;
  localparam int WDOG_CYC  = 3000;
  localparam int MAX_RETRY = 3;
  localparam int EXP_LINES = 480;

`ifdef CSI_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csi_rx_link_ctrl_if bus ();

  csi_rx_link_ctrl #(
    .PWRUP_CYC (PWRUP_CYC),
    .RST_CYC   (RST_CYC),
    .WDOG_CYC  (WDOG_CYC),
    .MAX_RETRY (MAX_RETRY),
    .EXP_LINES (EXP_LINES)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;

  // frame_err is sampled at the active edge, i.e. the value held through the prior cycle.
  always @(posedge clk) if (bus.frame_err === 1'b1) err_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       start;
    logic       in_frame;
    logic       in_line;
    int         cyc;
    logic [2:0] st;
    logic       cam;
    logic       lrst;
    logic       up;
    logic       fl;
    logic [3:0] rc;
  } vec_t;

  vec_t vecs[8];

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_line = 1'b1; cycles(2);
      bus.in_line = 1'b0; cycles(2);
    end
  endtask

  task automatic end_frame();
    cycles(2);
    bus.in_frame = 1'b0;
    cycles(6);
  endtask

  task automatic frame(input int n);
    bus.in_frame = 1'b1;
    cycles(4);
    lines(n);
    end_frame();
  endtask

  task automatic wait_link_released(input string name);
    int n = 0;
    while (bus.link_reset !== 1'b0 && n < PWRUP_CYC + RST_CYC + 50) begin
      cycles(1);
      n++;
    end
    check(name, bus.link_reset, 0);
  endtask

  task automatic bring_up();
    bus.start = 1'b1;
    wait_link_released("bringup_release");
    check("bringup_wait_sof", bus.state, 3);
    bus.in_frame = 1'b1;
    cycles(4);
    check("bringup_stream", bus.state, 4);
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.in_frame = 1'b0; bus.in_line = 1'b0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
  endtask

  initial begin
    int n;
    int e0;

    vecs[0] = '{"pwrup_entry",   1, 0, 0,  1, 3'd1, 1, 1, 0, 0, 4'd0};
    vecs[1] = '{"pwrup_end",     1, 0, 0, 19, 3'd1, 1, 1, 0, 0, 4'd0};
    vecs[2] = '{"lrst_entry",    1, 0, 0,  1, 3'd2, 1, 1, 0, 0, 4'd0};
    vecs[3] = '{"lrst_end",      1, 0, 0, 15, 3'd2, 1, 1, 0, 0, 4'd0};
    vecs[4] = '{"wait_sof",      1, 0, 0,  1, 3'd3, 1, 0, 0, 0, 4'd0};
    vecs[5] = '{"wait_sof_hold", 1, 0, 0, 10, 3'd3, 1, 0, 0, 0, 4'd0};
    vecs[6] = '{"sof_in_sync",   1, 1, 0,  3, 3'd3, 1, 0, 0, 0, 4'd0};
    vecs[7] = '{"stream_entry",  1, 1, 0,  1, 3'd4, 1, 0, 1, 0, 4'd0};

    bus.start = 1'b0; bus.in_frame = 1'b0; bus.in_line = 1'b0;
    cycles(3);

    // Reset values while reset is held
    check("rst_state", bus.state, 0);
    check("rst_cam_en", bus.cam_en, 0);
    check("rst_link_reset", bus.link_reset, 1);
    check("rst_link_up", bus.link_up, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_retry_cnt", bus.retry_cnt, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    check("rst_lines_last", bus.lines_last, 0);

    rst = 1'b0;
    cycles(2);
    check("idle_hold", bus.state, 0);

    // Bring-up sequence from the table
    for (int i = 0; i < 8; i++) begin
      bus.start    = vecs[i].start;
      bus.in_frame = vecs[i].in_frame;
      bus.in_line  = vecs[i].in_line;
      cycles(vecs[i].cyc);
      check({vecs[i].name, "_state"}, bus.state, vecs[i].st);
      check({vecs[i].name, "_cam_en"}, bus.cam_en, vecs[i].cam);
      check({vecs[i].name, "_link_reset"}, bus.link_reset, vecs[i].lrst);
      check({vecs[i].name, "_link_up"}, bus.link_up, vecs[i].up);
      check({vecs[i].name, "_fail"}, bus.fail, vecs[i].fl);
      check({vecs[i].name, "_retry_cnt"}, bus.retry_cnt, vecs[i].rc);
    end

    // Frame 1: 480 lines (matches EXP_LINES), started by the table's sof
    e0 = err_pulses;
    lines(480);
    end_frame();
    cycles(2);
    check("f480_err_pulses", err_pulses - e0, 0);
    check("f480_lines_last", bus.lines_last, STATS ? 480 : 0);
    check("f480_frame_cnt", bus.frame_cnt, STATS ? 1 : 0);

    // Frame 2: 479 lines -> exactly one frame_err cycle
    e0 = err_pulses;
    frame(479);
    cycles(2);
    check("f479_err_pulses", err_pulses - e0, 1);
    check("f479_lines_last", bus.lines_last, STATS ? 479 : 0);
    check("f479_frame_cnt", bus.frame_cnt, STATS ? 2 : 0);
    check("f479_state", bus.state, 4);

    // Frames stop: first watchdog expiry from STREAM
    n = 0;
    while (bus.link_reset !== 1'b1 && n < WDOG_CYC + 100) begin
      cycles(1);
      n++;
    end
    check("wdog1_link_reset", bus.link_reset, 1);
    check("wdog1_state", bus.state, 2);
    check("wdog1_retry_cnt", bus.retry_cnt, 1);
    check("wdog1_cam_en", bus.cam_en, 1);
    check("wdog1_frame_cnt", bus.frame_cnt, 0);
    n = 0;
    while (bus.link_reset === 1'b1 && n < 100) begin
      n++;
      cycles(1);
    end
    check("retry_link_reset_len", n, RST_CYC);

    // Three more expiries with no frames: FAIL on the 4th timeout
    n = 0;
    while (bus.fail !== 1'b1 && n < 4 * WDOG_CYC) begin
      cycles(1);
      n++;
    end
    check("fail_delay", n, 3 * WDOG_CYC + 2 * RST_CYC);
    check("fail_state", bus.state, 5);
    check("fail_cam_en", bus.cam_en, 0);
    check("fail_link_reset", bus.link_reset, 1);
    check("fail_retry_cnt", bus.retry_cnt, 3);
    cycles(5);
    check("fail_sticky", bus.state, 5);
    bus.start = 1'b0;
    cycles(1);
    check("fail_to_idle_state", bus.state, 0);
    check("fail_to_idle_fail", bus.fail, 0);

    // start dropped in the same cycle the sof is seen in WAIT_SOF
    bus.start = 1'b1;
    wait_link_released("drop_release");
    check("drop_wait_sof", bus.state, 3);
    check("drop_retry_cleared", bus.retry_cnt, 0);
    bus.in_frame = 1'b1;
    cycles(3);
    bus.start = 1'b0;
    cycles(1);
    check("drop_state", bus.state, 0);
    check("drop_cam_en", bus.cam_en, 0);
    check("drop_link_up", bus.link_up, 0);
    check("drop_link_reset", bus.link_reset, 1);
    bus.in_frame = 1'b0;
    cycles(6);

    // Asynchronous reset in the middle of STREAM
    bring_up();
    lines(5);
    end_frame();
    check("pre_rst_lines_last", bus.lines_last, STATS ? 5 : 0);
    bus.in_frame = 1'b1;
    cycles(4);
    lines(2);
    #2 rst = 1'b1;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_link_up", bus.link_up, 0);
    check("arst_cam_en", bus.cam_en, 0);
    check("arst_link_reset", bus.link_reset, 1);
    check("arst_frame_cnt", bus.frame_cnt, 0);
    check("arst_lines_last", bus.lines_last, 0);
    do_reset();
    check("post_rst_idle", bus.state, 0);

    // Ten short frames
    e0 = err_pulses;
    bring_up();
    lines(3);
    end_frame();
    for (int f = 0; f < 9; f++) frame(3);
    cycles(2);
    check("ten_state", bus.state, 4);
    check("ten_link_up", bus.link_up, 1);
    check("ten_frame_cnt", bus.frame_cnt, STATS ? 10 : 0);
    check("ten_lines_last", bus.lines_last, STATS ? 3 : 0);
    check("ten_err_pulses", err_pulses - e0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
